// File: rtl/mem_port_arbiter.sv
// Two-to-one shared memory port arbiter: data has fixed priority over fetch, with a burst limit so fetch always progresses.
// Optional ARB_STATS_EN macro adds saturating stall/grant statistics counters.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int D_BURST_MAX = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_rd,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic                    d_rd,
  input  logic                    d_wr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_waitrequest,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_waitrequest,
  output logic [31:0]             stat_i_stall,
  output logic [31:0]             stat_d_grant
);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  state_t     state;
  logic [3:0] dcnt;
  logic       ireq, dreq, gnt_i, gnt_d, i_done, d_done;

  assign ireq = i_rd;
  assign dreq = d_rd | d_wr;

  // A held lock overrides priority; only IDLE arbitrates.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    case (state)
      LOCK_I:  gnt_i = 1'b1;
      LOCK_D:  gnt_d = 1'b1;
      default: begin
        if (dreq && !(ireq && dcnt == 4'(D_BURST_MAX))) gnt_d = 1'b1;
        else if (ireq)                                  gnt_i = 1'b1;
      end
    endcase
  end

  assign i_done = gnt_i & ~mem_waitrequest;
  assign d_done = gnt_d & ~mem_waitrequest;

  always_comb begin
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    mem_be    = '0;
    if (gnt_d) begin
      mem_addr  = d_addr;
      mem_rd    = d_rd;
      mem_wr    = d_wr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (gnt_i) begin
      mem_addr  = i_addr;
      mem_rd    = i_rd;
      mem_be    = '1;
    end
  end

  assign i_waitrequest = gnt_i ? mem_waitrequest : 1'b1;
  assign d_waitrequest = gnt_d ? mem_waitrequest : 1'b1;
  assign i_rdata       = mem_rdata;
  assign d_rdata       = mem_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_waitrequest) begin
            if (gnt_d)      state <= LOCK_D;
            else if (gnt_i) state <= LOCK_I;
          end
        end
        default: if (!mem_waitrequest) state <= IDLE;
      endcase
      // Counts data wins only while fetch is waiting; saturates at the limit.
      if (!ireq || i_done)                              dcnt <= '0;
      else if (d_done && dcnt != 4'(D_BURST_MAX))       dcnt <= dcnt + 4'd1;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_i_stall <= '0;
      stat_d_grant <= '0;
    end else begin
      if (i_rd && i_waitrequest && stat_i_stall != '1) stat_i_stall <= stat_i_stall + 32'd1;
      if (d_done && stat_d_grant != '1)                stat_d_grant <= stat_d_grant + 32'd1;
    end
  end
`else
  assign stat_i_stall = '0;
  assign stat_d_grant = '0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory/cache port between two requesters: the instruction-fetch port (read-only) and the load/store data port (read/write).
- Forwards the winning request to the shared port in the same cycle.
- Holds the grant until the shared port drops waitrequest, and stalls the losing requester with its own waitrequest.
- Fixed priority to data, with an anti-starvation limit so fetch always progresses.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- D_BURST_MAX, 4, max back-to-back data grants while fetch is pending (1..15)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_addr  in  ADDR_WIDTH  fetch address
- i_rd  in  1  fetch read request
- i_rdata  out  DATA_WIDTH  fetch read data
- i_waitrequest  out  1  fetch stall; transfer completes in a cycle where i_rd=1 and this is 0
- d_addr  in  ADDR_WIDTH  data address
- d_rd  in  1  data read request
- d_wr  in  1  data write request (d_rd and d_wr never both 1)
- d_wdata  in  DATA_WIDTH  write data
- d_be  in  DATA_WIDTH/8  byte enables
- d_rdata  out  DATA_WIDTH  data read data
- d_waitrequest  out  1  data stall
- mem_addr  out  ADDR_WIDTH  shared port address
- mem_rd  out  1  shared port read
- mem_wr  out  1  shared port write
- mem_wdata  out  DATA_WIDTH  shared port write data
- mem_be  out  DATA_WIDTH/8  shared port byte enables (all ones for fetch)
- mem_rdata  in  DATA_WIDTH  shared port read data, valid when mem_waitrequest=0
- mem_waitrequest  in  1  shared port stall
- stat_i_stall  out  32  fetch stall-cycle counter (optional feature)
- stat_d_grant  out  32  completed data-transfer counter (optional feature)

Behaviour:
- Requester contract: holds request, address and data stable until it sees its waitrequest=0.
- Request definitions: ireq=i_rd; dreq=d_rd|d_wr.
- States: IDLE, LOCK_I, LOCK_D.
- IDLE, winner selection (combinational):
  - dreq only: D wins.
  - ireq only: I wins.
  - both: D wins unless dcnt==D_BURST_MAX, then I wins.
- Winner's signals drive mem_* in the same cycle (zero added latency).
  - mem_waitrequest=0: transfer completes that cycle; state stays IDLE.
  - mem_waitrequest=1: go to LOCK_I/LOCK_D.
- LOCK_x: mem_* driven from requester x regardless of the other request.
  - Return to IDLE in the cycle mem_waitrequest=0; the transfer completes that cycle.
  - No re-arbitration in that cycle.
- Granted requester: its waitrequest = mem_waitrequest.
- Non-granted requester with an active request: waitrequest=1.
- Idle requester: waitrequest=1. Don't-care, but fixed at 1 for determinism.
- No request (IDLE): mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, mem_be=0.
- i_rdata and d_rdata both = mem_rdata at all times; the waitrequest qualifies which is valid.
- dcnt, 4-bit:
  - Increments on each completed D transfer while ireq=1; saturates at D_BURST_MAX.
  - Cleared on any completed I transfer.
  - Cleared in any cycle with ireq=0.
- Reset (asynchronous, any time including mid-transfer):
  - state=IDLE, dcnt=0, stats=0.
  - The lock is dropped; an in-flight transfer is abandoned.
  - Outputs follow IDLE rules immediately.
- mem_waitrequest=1 indefinitely: the lock is held indefinitely; the other requester stalls. No timeout.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - stat_i_stall increments each cycle with i_rd=1 and i_waitrequest=1.
  - stat_d_grant increments on each completed D transfer.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
  - Both are cleared by reset.
- Not defined: stat_* outputs tied to 0; no counter logic synthesized.

Test Plan:
- Fetch only, mem_waitrequest=0:
  - i_rd=1, i_addr=0x100 → mem_rd=1, mem_addr=0x100, mem_be=0xF, i_waitrequest=0 same cycle.
  - mem_rdata=0xDEADBEEF appears on i_rdata.
- Data write under stall:
  - d_wr=1, d_addr=0x2000, d_wdata=0x12345678, d_be=0x3, mem_waitrequest=1 for 3 cycles.
  - State LOCK_D, d_waitrequest=1 for 3 cycles, then 0; mem_wr=1 for 4 cycles.
  - An i_rd raised in cycle 2 sees i_waitrequest=1 until D completes.
- Anti-starvation:
  - D_BURST_MAX=4; i_rd and d_rd held continuously; mem_waitrequest=0.
  - Grant sequence D,D,D,D,I,D,D,D,D,I.
- Lock held against priority:
  - I granted with mem_waitrequest=1; d_rd asserted next cycle.
  - mem_* stay on i_addr until mem_waitrequest=0; D is served in the following cycle.
- Reset mid-lock:
  - Assert reset during LOCK_D → same cycle mem_wr=0, mem_rd=0 (no requests), state IDLE, dcnt=0.
  - After release, pending i_rd is granted first if d_rd is low.
- ARB_STATS_EN:
  - 5 stalled fetch cycles and 2 completed D transfers → stat_i_stall=5, stat_d_grant=2.
  - Without the macro, both read 0.
